// File: rtl/cpu_run_sequencer.sv
// Batch controller for the egg-drop CPU: accepts one experiment config, holds the
// CPU in reset, runs it until the PC parks at the halt address or time runs out, then returns the captured results.
module cpu_run_sequencer #(
   parameter int unsigned RESET_CYCLES  = 4,
   parameter logic [31:0] HALT_PC       = 32'h0000_00FC,
   parameter int unsigned STABLE_CYCLES = 8,
   parameter int unsigned TIMEOUT       = 100000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cfg_valid_i,
   output logic        cfg_ready_o,
   input  logic [31:0] cfg_floors_i,
   input  logic [31:0] cfg_resistance_i,
   input  logic        abort_i,
   output logic        cpu_rst_o,
   output logic [31:0] cpu_floors_o,
   output logic [31:0] cpu_resistance_o,
   input  logic [31:0] cpu_pc_i,
   input  logic [31:0] cpu_attempt_i,
   input  logic [31:0] cpu_broken_i,
   input  logic        cpu_last_broken_i,
   input  logic [31:0] cpu_cost_f1_i,
   input  logic [31:0] cpu_cost_f2_i,
   output logic        res_valid_o,
   input  logic        res_ready_i,
   output logic [31:0] res_attempt_o,
   output logic [31:0] res_broken_o,
   output logic        res_last_broken_o,
   output logic [31:0] res_cost_f1_o,
   output logic [31:0] res_cost_f2_o,
   output logic [31:0] res_cycles_o,
   output logic        res_timeout_o,
   output logic        busy_o
);

   localparam logic [31:0] RST_LAST    = 32'(RESET_CYCLES - 1);
   localparam logic [31:0] STABLE_LAST = 32'(STABLE_CYCLES - 1);
   localparam logic [31:0] TMO_LAST    = 32'(TIMEOUT - 1);
   localparam logic [31:0] TMO_VAL     = 32'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RESET,
      S_RUN,
      S_RESULT
   } state_t;

   state_t      state, state_nx;
   logic [31:0] rst_cnt;
   logic [31:0] run_cnt;
   logic [31:0] stable_cnt;
   logic        pc_match;
   logic        halt;
   logic        timeout;
   logic        accept;
   logic        capture;

   assign pc_match = (cpu_pc_i == HALT_PC);
   assign halt     = pc_match && (stable_cnt == STABLE_LAST);
   assign timeout  = (run_cnt == TMO_LAST);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Abort outranks halt/timeout, and halt outranks timeout via the capture mux below.
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      capture  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (cfg_valid_i) begin
               accept   = 1'b1;
               state_nx = S_RESET;
            end
         end
         S_RESET: begin
            if (abort_i)                    state_nx = S_IDLE;
            else if (rst_cnt == RST_LAST)   state_nx = S_RUN;
         end
         S_RUN: begin
            if (abort_i) begin
               state_nx = S_IDLE;
            end else if (halt || timeout) begin
               capture  = 1'b1;
               state_nx = S_RESULT;
            end
         end
         S_RESULT: begin
            if (res_ready_i) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Reset forces every output except cpu_rst_o low, including the IDLE-decoded ready.
   assign cfg_ready_o = rst_i && (state == S_IDLE);
   assign busy_o      = (state == S_RESET) || (state == S_RUN);
   assign res_valid_o = (state == S_RESULT);
   assign cpu_rst_o   = (state != S_RUN);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cpu_floors_o      <= '0;
         cpu_resistance_o  <= '0;
         rst_cnt           <= '0;
         run_cnt           <= '0;
         stable_cnt        <= '0;
      end else begin
         if (accept) begin
            cpu_floors_o     <= cfg_floors_i;
            cpu_resistance_o <= cfg_resistance_i;
            rst_cnt          <= '0;
            run_cnt          <= '0;
            stable_cnt       <= '0;
         end else if (state == S_RESET) begin
            rst_cnt <= rst_cnt + 32'd1;
         end else if (state == S_RUN) begin
            run_cnt    <= run_cnt + 32'd1;
            stable_cnt <= pc_match ? stable_cnt + 32'd1 : '0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         res_attempt_o     <= '0;
         res_broken_o      <= '0;
         res_last_broken_o <= 1'b0;
         res_cost_f1_o     <= '0;
         res_cost_f2_o     <= '0;
         res_cycles_o      <= '0;
         res_timeout_o     <= 1'b0;
      end else if (capture) begin
         res_attempt_o     <= cpu_attempt_i;
         res_broken_o      <= cpu_broken_i;
         res_last_broken_o <= cpu_last_broken_i;
         res_cost_f1_o     <= cpu_cost_f1_i;
         res_cost_f2_o     <= cpu_cost_f2_i;
         res_cycles_o      <= halt ? run_cnt + 32'd1 : TMO_VAL;
         res_timeout_o     <= !halt;
      end
   end

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Directed bench for cpu_run_sequencer: a scripted CPU stand-in plus a run-timeline
// model checked against the DUT on every falling edge.
module tb_cpu_run_sequencer;

   localparam int unsigned R    = 4;
   localparam int unsigned S    = 8;
   localparam int unsigned TMO  = 200;
   localparam logic [31:0] HALT = 32'h0000_00FC;

   logic        clk_i;
   logic        rst_i;
   logic        cfg_valid_i;
   logic        cfg_ready_o;
   logic [31:0] cfg_floors_i;
   logic [31:0] cfg_resistance_i;
   logic        abort_i;
   logic        cpu_rst_o;
   logic [31:0] cpu_floors_o;
   logic [31:0] cpu_resistance_o;
   logic [31:0] cpu_pc_i;
   logic [31:0] cpu_attempt_i;
   logic [31:0] cpu_broken_i;
   logic        cpu_last_broken_i;
   logic [31:0] cpu_cost_f1_i;
   logic [31:0] cpu_cost_f2_i;
   logic        res_valid_o;
   logic        res_ready_i;
   logic [31:0] res_attempt_o;
   logic [31:0] res_broken_o;
   logic        res_last_broken_o;
   logic [31:0] res_cost_f1_o;
   logic [31:0] res_cost_f2_o;
   logic [31:0] res_cycles_o;
   logic        res_timeout_o;
   logic        busy_o;

   cpu_run_sequencer #(
      .RESET_CYCLES (R),
      .HALT_PC      (HALT),
      .STABLE_CYCLES(S),
      .TIMEOUT      (TMO)
   ) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .cfg_valid_i      (cfg_valid_i),
      .cfg_ready_o      (cfg_ready_o),
      .cfg_floors_i     (cfg_floors_i),
      .cfg_resistance_i (cfg_resistance_i),
      .abort_i          (abort_i),
      .cpu_rst_o        (cpu_rst_o),
      .cpu_floors_o     (cpu_floors_o),
      .cpu_resistance_o (cpu_resistance_o),
      .cpu_pc_i         (cpu_pc_i),
      .cpu_attempt_i    (cpu_attempt_i),
      .cpu_broken_i     (cpu_broken_i),
      .cpu_last_broken_i(cpu_last_broken_i),
      .cpu_cost_f1_i    (cpu_cost_f1_i),
      .cpu_cost_f2_i    (cpu_cost_f2_i),
      .res_valid_o      (res_valid_o),
      .res_ready_i      (res_ready_i),
      .res_attempt_o    (res_attempt_o),
      .res_broken_o     (res_broken_o),
      .res_last_broken_o(res_last_broken_o),
      .res_cost_f1_o    (res_cost_f1_o),
      .res_cost_f2_o    (res_cost_f2_o),
      .res_cycles_o     (res_cycles_o),
      .res_timeout_o    (res_timeout_o),
      .busy_o           (busy_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // Scenario: PC reaches HALT at 1-based RUN cycle sc_first (0 = never), except at sc_glitch.
   int unsigned sc_first  = 0;
   int unsigned sc_glitch = 0;
   logic [31:0] sc_att = '0, sc_brk = '0, sc_f1 = '0, sc_f2 = '0;
   logic        sc_last = 1'b0;

   function automatic logic [31:0] pc_at(input int unsigned k);
      if (sc_first != 0 && k >= sc_first && k != sc_glitch) return HALT;
      return 32'h1000 + k;
   endfunction

   int unsigned kcyc = 1;
   always @(posedge clk_i) kcyc <= cpu_rst_o ? 1 : kcyc + 1;

   always_comb begin
      cpu_pc_i = pc_at(kcyc);
      if (cpu_pc_i == HALT) begin
         cpu_attempt_i     = sc_att;
         cpu_broken_i      = sc_brk;
         cpu_last_broken_i = sc_last;
         cpu_cost_f1_i     = sc_f1;
         cpu_cost_f2_i     = sc_f2;
      end else begin
         cpu_attempt_i     = kcyc;
         cpu_broken_i      = kcyc + 1000;
         cpu_last_broken_i = 1'b0;
         cpu_cost_f1_i     = kcyc + 2000;
         cpu_cost_f2_i     = kcyc + 3000;
      end
   end

   function automatic void calc_run(output int unsigned len, output logic halted);
      int unsigned streak = 0;
      for (int unsigned k = 1; k <= TMO; k++) begin
         streak = (pc_at(k) == HALT) ? streak + 1 : 0;
         if (streak == S) begin
            len = k;
            halted = 1'b1;
            return;
         end
      end
      len = TMO;
      halted = 1'b0;
   endfunction

   // Timeline model: m_t counts cycles since acceptance; RESET spans 1..R,
   // RUN spans R+1..R+m_len, RESULT follows until the handshake.
   logic        m_active = 1'b0, m_halt = 1'b0;
   int unsigned m_t = 0, m_len = 0;
   logic [31:0] m_floors = '0, m_resist = '0;
   logic [31:0] p_att = '0, p_brk = '0, p_f1 = '0, p_f2 = '0;
   logic        p_last = 1'b0;
   logic [31:0] c_att = '0, c_brk = '0, c_f1 = '0, c_f2 = '0, c_cycles = '0;
   logic        c_last = 1'b0, c_to = 1'b0;

   initial begin
      int unsigned len;
      logic        h;
      forever begin
         @(posedge clk_i or negedge rst_i);
         if (!rst_i) begin
            m_active = 1'b0; m_t = 0; m_floors = '0; m_resist = '0;
            c_att = '0; c_brk = '0; c_f1 = '0; c_f2 = '0; c_cycles = '0;
            c_last = 1'b0; c_to = 1'b0;
         end else if (!m_active) begin
            if (cfg_valid_i) begin
               calc_run(len, h);
               m_active = 1'b1; m_t = 1; m_len = len; m_halt = h;
               m_floors = cfg_floors_i; m_resist = cfg_resistance_i;
               if (h) begin
                  p_att = sc_att; p_brk = sc_brk; p_last = sc_last; p_f1 = sc_f1; p_f2 = sc_f2;
               end else begin
                  p_att = TMO; p_brk = TMO + 1000; p_last = 1'b0; p_f1 = TMO + 2000; p_f2 = TMO + 3000;
               end
            end
         end else if (m_t <= R + m_len) begin
            if (abort_i) begin
               m_active = 1'b0;
            end else begin
               if (m_t == R + m_len) begin
                  c_att = p_att; c_brk = p_brk; c_last = p_last; c_f1 = p_f1; c_f2 = p_f2;
                  c_cycles = m_len; c_to = !m_halt;
               end
               m_t = m_t + 1;
            end
         end else if (res_ready_i) begin
            m_active = 1'b0;
         end
      end
   end

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned expired_cnt = 0;
   logic        lit_en = 1'b0;
   logic [31:0] lit_cycles = '0, lit_attempt = '0, lit_floors = '0;
   logic        lit_to = 1'b0;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk32(name, {31'b0, act}, {31'b0, exp});
   endtask

   initial begin
      int unsigned seen_exp = 0;
      logic e_run, e_busy, e_valid;
      forever begin
         @(negedge clk_i);
         e_busy  = m_active && (m_t <= R + m_len);
         e_run   = e_busy && (m_t > R);
         e_valid = m_active && (m_t > R + m_len);
         chk1 ("cfg_ready",   cfg_ready_o, rst_i && !m_active);
         chk1 ("busy",        busy_o, e_busy);
         chk1 ("cpu_rst",     cpu_rst_o, !e_run);
         chk1 ("res_valid",   res_valid_o, e_valid);
         chk32("cpu_floors",  cpu_floors_o, m_floors);
         chk32("cpu_resist",  cpu_resistance_o, m_resist);
         chk32("res_attempt", res_attempt_o, c_att);
         chk32("res_broken",  res_broken_o, c_brk);
         chk1 ("res_last",    res_last_broken_o, c_last);
         chk32("res_f1",      res_cost_f1_o, c_f1);
         chk32("res_f2",      res_cost_f2_o, c_f2);
         chk32("res_cycles",  res_cycles_o, c_cycles);
         chk1 ("res_timeout", res_timeout_o, c_to);
         if (lit_en && res_valid_o) begin
            chk32("lit_cycles",  res_cycles_o, lit_cycles);
            chk1 ("lit_timeout", res_timeout_o, lit_to);
            chk32("lit_attempt", res_attempt_o, lit_attempt);
         end
         if (lit_en && busy_o) chk32("lit_floors", cpu_floors_o, lit_floors);
         if (expired_cnt != seen_exp) begin
            chk32("wait_bound", expired_cnt, seen_exp);
            seen_exp = expired_cnt;
         end
      end
   end

   task automatic tick;
      @(negedge clk_i);
   endtask

   task automatic set_scn(input int unsigned first, input int unsigned glitch, input logic [31:0] att,
                          input logic [31:0] brk, input logic last, input logic [31:0] f1, input logic [31:0] f2);
      sc_first = first; sc_glitch = glitch;
      sc_att = att; sc_brk = brk; sc_last = last; sc_f1 = f1; sc_f2 = f2;
   endtask

   task automatic start_cfg(input logic [31:0] fl, input logic [31:0] rs, input logic [31:0] lcyc,
                            input logic lto, input logic [31:0] latt);
      lit_en = 1'b1; lit_cycles = lcyc; lit_to = lto; lit_attempt = latt; lit_floors = fl;
      cfg_valid_i = 1'b1; cfg_floors_i = fl; cfg_resistance_i = rs;
      tick;
      cfg_valid_i = 1'b0;
   endtask

   task automatic wait_valid;
      for (int i = 0; i < 500; i++) begin
         if (res_valid_o) return;
         tick;
      end
      expired_cnt++;
   endtask

   task automatic wait_run(input int unsigned k);
      for (int i = 0; i < 500; i++) begin
         if (!cpu_rst_o && kcyc == k) return;
         tick;
      end
      expired_cnt++;
   endtask

   task automatic take_result;
      res_ready_i = 1'b1;
      tick;
      res_ready_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1; cfg_valid_i = 1'b0; cfg_floors_i = '0; cfg_resistance_i = '0;
      abort_i = 1'b0; res_ready_i = 1'b0;
      #1 rst_i = 1'b0;
      repeat (3) tick;
      rst_i = 1'b1;
      tick;
      abort_i = 1'b1; tick; abort_i = 1'b0; tick;

      // basic run: halt reached at RUN cycle 50, declared at 57
      set_scn(50, 0, 9, 3, 1'b1, 12, 15);
      start_cfg(100, 7, 57, 1'b0, 9);
      wait_valid; take_result; tick;

      // timeout: counters captured at RUN cycle 200
      set_scn(0, 0, 0, 0, 1'b0, 0, 0);
      start_cfg(20, 5, 200, 1'b1, 200);
      wait_valid; take_result; tick;

      // PC glitch: 5 matches, one miss, then 8 fresh matches end at cycle 63
      set_scn(50, 55, 9, 3, 1'b1, 12, 15);
      start_cfg(100, 7, 63, 1'b0, 9);
      wait_valid; take_result; tick;

      // backpressure then back-to-back config
      set_scn(30, 0, 4, 2, 1'b0, 6, 8);
      start_cfg(64, 3, 37, 1'b0, 4);
      wait_valid;
      repeat (10) tick;
      res_ready_i = 1'b1; tick; res_ready_i = 1'b0;
      set_scn(5, 0, 21, 22, 1'b1, 23, 24);
      start_cfg(10, 2, 12, 1'b0, 21);
      wait_valid; take_result; tick;

      // abort at RUN cycle 20
      set_scn(50, 0, 9, 3, 1'b1, 12, 15);
      start_cfg(33, 1, 0, 1'b0, 0);
      wait_run(20);
      abort_i = 1'b1; tick; abort_i = 1'b0;
      repeat (5) tick;

      // asynchronous reset mid-run
      start_cfg(44, 2, 0, 1'b0, 0);
      wait_run(30);
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      tick; tick;
      rst_i = 1'b1;
      tick;

      // abort coincident with the halt cycle
      set_scn(10, 0, 5, 6, 1'b1, 7, 8);
      start_cfg(55, 6, 0, 1'b0, 0);
      wait_run(17);
      abort_i = 1'b1; tick; abort_i = 1'b0;
      repeat (5) tick;

      // recovery run
      set_scn(5, 0, 31, 32, 1'b0, 33, 34);
      start_cfg(7, 7, 12, 1'b0, 31);
      wait_valid; take_result;
      repeat (2) tick;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cpu_run_sequencer.md
Name: cpu_run_sequencer

Overview:
- Batch controller that runs the pipelined egg-drop CPU once per experiment configuration.
- Accepts a (floors, resistance) pair over a valid/ready handshake and drives the CPU's init values and reset.
- Detects program completion (PC parked at the halt address) or a timeout, snapshots the CPU result counters and cost outputs, and presents them on a valid/ready result port.
- Sits between the test host/bench and the CPU top level, owning the CPU's reset line.

Parameters:
- RESET_CYCLES, 4, cycles cpu_rst_o is held high after a config is accepted (≥1).
- HALT_PC, 32'h0000_00FC, PC value that marks program end (self-loop).
- STABLE_CYCLES, 8, consecutive cycles PC must equal HALT_PC to declare completion, so the pipeline drains (≥1).
- TIMEOUT, 100000, maximum RUN cycles before a forced stop (≥1).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- cfg_valid_i  in  1  config valid.
- cfg_ready_o  out  1  config ready.
- cfg_floors_i  in  32  floors for the next run.
- cfg_resistance_i  in  32  egg resistance for the next run.
- abort_i  in  1  synchronous abort of the current run.
- cpu_rst_o  out  1  active-high reset to the CPU.
- cpu_floors_o  out  32  init_floors to the CPU.
- cpu_resistance_o  out  32  init_resistance to the CPU.
- cpu_pc_i  in  32  CPU fetch PC.
- cpu_attempt_i  in  32  CPU attempt count.
- cpu_broken_i  in  32  CPU broken count.
- cpu_last_broken_i  in  1  CPU last-broken flag.
- cpu_cost_f1_i  in  32  CPU cost f1.
- cpu_cost_f2_i  in  32  CPU cost f2.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  result ready.
- res_attempt_o  out  32  captured attempt count.
- res_broken_o  out  32  captured broken count.
- res_last_broken_o  out  1  captured last-broken flag.
- res_cost_f1_o  out  32  captured cost f1.
- res_cost_f2_o  out  32  captured cost f2.
- res_cycles_o  out  32  RUN cycles consumed.
- res_timeout_o  out  1  1 = run ended by timeout.
- busy_o  out  1  high in RESET or RUN.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - State goes to IDLE.
  - cpu_rst_o=1; every other output and all counters are 0.
  - Takes effect mid-run too: the in-flight run and any pending result are discarded.
- States: IDLE, RESET, RUN, RESULT.
- IDLE:
  - cfg_ready_o=1, cpu_rst_o=1.
  - On cfg_valid_i&cfg_ready_o, register the config into cpu_floors_o/cpu_resistance_o, clear the counters and go to RESET.
  - abort_i is ignored.
- RESET:
  - cpu_rst_o=1 for exactly RESET_CYCLES cycles, then go to RUN.
  - cpu_floors_o/cpu_resistance_o are held constant from acceptance until the next acceptance.
- RUN:
  - cpu_rst_o=0.
  - run_cnt starts at 0 and increments every RUN cycle.
  - stable_cnt increments when cpu_pc_i==HALT_PC and clears otherwise.
  - Halt condition: cpu_pc_i==HALT_PC and stable_cnt==STABLE_CYCLES-1.
  - On halt, capture all cpu_* result inputs in that same cycle, set res_cycles_o=run_cnt+1 and res_timeout_o=0, then go to RESULT.
  - Timeout: run_cnt==TIMEOUT-1 and no halt. Capture the same way with res_timeout_o=1 and res_cycles_o=TIMEOUT.
  - If halt and timeout occur in the same cycle, halt wins (timeout=0).
- abort_i in RESET or RUN: go to IDLE next cycle with no result. Abort takes priority over halt and timeout in the same cycle.
- RESULT:
  - res_valid_o=1, cpu_rst_o=1.
  - res_* outputs are stable until the handshake; on res_valid_o&res_ready_i go to IDLE.
  - res_valid_o drops the next cycle; res_* data keeps its last value until the next capture.
  - cfg_ready_o=0, so no new config is accepted until the result is taken.
- Outputs: cfg_ready_o and busy_o are decoded from the state (Moore); all data outputs are registered.
- Latency, accept to first RUN cycle: RESET_CYCLES+1 edges.
- Counter width: 32 bits, no wrap reachable because TIMEOUT bounds run_cnt.

Test Plan:
- Basic run: RESET_CYCLES=4, STABLE_CYCLES=8. Accept (100, 7); CPU model reaches PC=HALT_PC at RUN cycle 50 and holds it, reporting attempt=9, broken=3, last=1, f1=12, f2=15 → cpu_rst_o high for 4 cycles; res_valid_o rises with res_cycles_o=57, timeout=0 and those values.
- Timeout: TIMEOUT=200, PC never reaches HALT_PC → res_valid_o with res_timeout_o=1, res_cycles_o=200, counters captured at RUN cycle 200.
- PC glitch: PC equals HALT_PC for 5 cycles, leaves for 1, then holds → completion only after 8 new consecutive matches; res_cycles_o reflects the later point.
- Backpressure and back-to-back: res_ready_i low for 10 cycles → res_* stable and cfg_ready_o=0 throughout; on ready, IDLE, then a second config (10, 2) is accepted the following cycle and cpu_floors_o=10.
- Abort: abort_i pulsed at RUN cycle 20 → IDLE next cycle, cpu_rst_o=1, no res_valid_o.
- Async reset: rst_i low at RUN cycle 30 → immediate cpu_rst_o=1 and IDLE with all outputs 0; abort_i=1 coincident with the halt cycle → no result.
